regfile_gen: RTL
================

REGFILE_GEN -- requirements
Module: regfile_gen

Interface
REQ-001 Parameter XLEN, default 64, data width of each register and of the read/write data ports.
REQ-002 Parameter NREG, default 32, number of architectural registers; power of two, 2..64.
REQ-003 Parameter AW, default $clog2(NREG), width of register address ports; derived, not overridden.
REQ-004 Parameter INIT_MODE, default 0: 0 = initialise every register to zero; 1 = initialise register i to i+1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rs1  input  AW  read port 1 address.
REQ-008 rs2  input  AW  read port 2 address.
REQ-009 rd  input  AW  write address.
REQ-010 regWrite  input  1  write enable.
REQ-011 writeData  input  XLEN  write data.
REQ-012 readData1  output  XLEN  read port 1 data, combinational.
REQ-013 readData2  output  XLEN  read port 2 data, combinational.
REQ-014 ready  output  1  high when the init sweep is complete and the file accepts reads and writes.

Function
REQ-015 The block SHALL hold a two-state FSM: INIT (sweep in progress) and READY.
REQ-016 In INIT, each non-reset clock SHALL write the INIT_MODE value to register idx, then increment idx by 1.
REQ-017 When idx = NREG-1 is written, the FSM SHALL move to READY on that same edge; idx does not wrap.
REQ-018 ready SHALL equal 1 only in READY; ready SHALL rise on the NREG-th rising edge after reset deasserts.
REQ-019 In INIT, regWrite SHALL be ignored, and readData1/readData2 SHALL be 0.
REQ-020 In READY, regWrite=1 with rd != 0 SHALL write writeData to register rd on the rising edge.
REQ-021 Writes to rd = 0 SHALL be discarded.
REQ-022 Address 0 SHALL always read 0, regardless of INIT_MODE or write history.
REQ-023 In READY, readDataN SHALL equal the contents of register rsN, for rsN != 0.
REQ-024 Same-cycle bypass: in READY, if regWrite=1, rd = rsN and rd != 0, readDataN SHALL equal writeData (not the stored value).
REQ-025 rs1 = rs2 SHALL return identical data on both ports, including when bypassed.
REQ-026 Read latency SHALL be zero cycles; write-to-read visibility SHALL be zero cycles via bypass, and one edge via storage.
REQ-027 Register storage SHALL NOT use initial blocks; all initial contents SHALL come from the sweep.
REQ-028 Registers not yet reached by the sweep SHALL never be observable on the outputs.

Reset
REQ-029 reset=1 at a rising edge SHALL set the FSM to INIT, idx to 0 and ready to 0.
REQ-030 While reset=1, readData1/readData2 SHALL be 0, and no register SHALL be written.
REQ-031 reset asserted mid-sweep or in READY SHALL discard progress; the sweep SHALL restart at idx 0 after deassertion.
REQ-032 reset and regWrite both high SHALL cause reset to win; the write SHALL be dropped.

Verification
REQ-033 Init timing: XLEN=64, NREG=32. Hold reset 2 cycles, then release -> ready=0 for 31 edges, ready=1 at the 32nd edge. Reads during the sweep = 0.
REQ-034 INIT_MODE=1 contents: after ready, read rs1=5, rs2=31 -> readData1=6, readData2=32. rs1=0 -> 0.
REQ-035 Write/bypass: in READY, regWrite=1, rd=7, writeData=0xDEAD_BEEF, rs1=7 -> readData1=0xDEAD_BEEF in the same cycle. After the edge with regWrite=0 -> still 0xDEAD_BEEF.
REQ-036 x0 protection: regWrite=1, rd=0, writeData=0xFFFF_FFFF_FFFF_FFFF, rs1=rs2=0 -> both outputs 0 in the same cycle and after the edge.
REQ-037 Write during INIT and reset mid-sweep: regWrite=1, rd=3, writeData=0x55 while ready=0 -> ignored; after ready, reg 3 = init value (0 or 4). Assert reset at sweep edge 10 -> ready reasserts exactly 32 edges after the new deassertion.
REQ-038 Parameter sweep: XLEN=32, NREG=16, INIT_MODE=0 -> ready at the 16th edge; all reads 0; write rd=15 value 0x1234_5678 then read back -> 0x1234_5678.

Source files
------------

// File: rtl/regfile_gen.sv
// Register file with a power-on init sweep, x0 hardwired to zero,
// two combinational read ports with write bypass and one write port.
// Ports: clk, reset (sync, active-high), rs1/rs2 read addresses,
// rd/regWrite/writeData write port, readData1/readData2, ready.
module regfile_gen #(
  parameter int XLEN      = 64,
  parameter int NREG      = 32,
  parameter int AW        = $clog2(NREG),
  parameter int INIT_MODE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic            regWrite,
  input  logic [XLEN-1:0] writeData,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  output logic            ready
);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   idx_nx;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] init_val;
  logic            live;
  logic [XLEN-1:0] regs [NREG];

  assign init_val = (INIT_MODE == 1)
                  ? XLEN'(idx) + XLEN'(1)
                  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // The sweep owns the write port while in INIT; user writes
  // are only honoured once READY.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    wr_en    = 1'b0;
    wr_addr  = idx;
    wr_data  = init_val;
    unique case (state)
      INIT: begin
        wr_en = 1'b1;
        if (idx == LAST) state_nx = READY;
        else             idx_nx   = idx + AW'(1);
      end
      READY: begin
        wr_en   = regWrite && (rd != '0);
        wr_addr = rd;
        wr_data = writeData;
      end
      default: ;
    endcase
    if (reset) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) regs[wr_addr] <= wr_data;
  end

  assign ready = (state == READY);

  // Gating on live hides unswept (undefined) storage.
  assign live = (state == READY) && !reset;

  always_comb begin
    readData1 = '0;
    if (live && rs1 != '0) begin
      if (regWrite && rd == rs1) readData1 = writeData;
      else                       readData1 = regs[rs1];
    end
  end

  always_comb begin
    readData2 = '0;
    if (live && rs2 != '0) begin
      if (regWrite && rd == rs2) readData2 = writeData;
      else                       readData2 = regs[rs2];
    end
  end

endmodule
